// File: rtl/assist_pkg.sv
// Shared types and constants for the assistive-actuator arbiter.
package assist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StCooldown
  } state_e;

  localparam int unsigned REQ_EMERG = 3;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned CMD_W     = 4;

  // Round-robin pointer only ever holds 0..2.
  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/assist_actuator_arbiter_rr_pick3.sv
// Combinational round-robin pick among requesters 0..2, starting at ptr_i.
module rr_pick3
  import assist_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] win_o,
  output logic       found_o
);

  logic [1:0] c0, c1, c2;

  assign c0 = (ptr_i > 2'd2) ? 2'd0 : ptr_i;
  assign c1 = inc_mod3(c0);
  assign c2 = inc_mod3(c1);

  always_comb begin
    win_o   = '0;
    found_o = 1'b0;
    if (req_i[c0]) begin
      win_o[c0] = 1'b1;
      found_o   = 1'b1;
    end else if (req_i[c1]) begin
      win_o[c1] = 1'b1;
      found_o   = 1'b1;
    end else if (req_i[c2]) begin
      win_o[c2] = 1'b1;
      found_o   = 1'b1;
    end
  end

endmodule

// File: rtl/assist_actuator_arbiter.sv
// Shares one actuator among four requesters: fixed-priority emergency, round-robin
// for the rest, valid/ready issue, done-or-timeout wait and a fixed cooldown.
module assist_actuator_arbiter
  import assist_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned COOL_CYCLES    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CMD_W-1:0] cmd_flat,
  input  logic                     act_ready,
  input  logic                     act_done,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     act_valid,
  output logic [CMD_W-1:0]         act_cmd,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [NUM_REQ-1:0]       led
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CoolW  = $clog2(COOL_CYCLES + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [NUM_REQ-1:0] led_q, led_d;
  logic               err_q, err_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [CoolW-1:0]   cool_q, cool_d;

  logic [2:0] rr_win;
  logic       rr_found;

  rr_pick3 u_rr_pick3 (
    .req_i   (req[2:0]),
    .ptr_i   (ptr_q),
    .win_o   (rr_win),
    .found_o (rr_found)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    led_d   = led_q;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    cool_d  = cool_q;
    unique case (state_q)
      StIdle: begin
        if (req[REQ_EMERG]) begin
          grant_d = 4'b1000;
          cmd_d   = cmd_flat[REQ_EMERG*CMD_W +: CMD_W];
          state_d = StIssue;
        end else if (rr_found) begin
          grant_d = {1'b0, rr_win};
          state_d = StIssue;
          unique case (1'b1)
            rr_win[0]: begin cmd_d = cmd_flat[0 +: CMD_W];       ptr_d = 2'd1; end
            rr_win[1]: begin cmd_d = cmd_flat[CMD_W +: CMD_W];   ptr_d = 2'd2; end
            rr_win[2]: begin cmd_d = cmd_flat[2*CMD_W +: CMD_W]; ptr_d = 2'd0; end
            default: ;
          endcase
        end
      end
      StIssue: begin
        // Acceptance beats a simultaneous emergency preemption.
        if (act_ready) begin
          led_d   = grant_q;
          timer_d = '0;
          state_d = StWaitDone;
        end else if (!grant_q[REQ_EMERG] && req[REQ_EMERG]) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (act_done) begin
          grant_d = '0;
          cool_d  = '0;
          state_d = StCooldown;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          grant_d = '0;
          cool_d  = '0;
          err_d   = 1'b1;
          state_d = StCooldown;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StCooldown: begin
        if (cool_q == CoolW'(COOL_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          cool_d = cool_q + CoolW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      cmd_q   <= '0;
      led_q   <= '0;
      err_q   <= 1'b0;
      ptr_q   <= 2'd0;
      timer_q <= '0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      led_q   <= led_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      cool_q  <= cool_d;
    end
  end

  assign grant       = grant_q;
  assign act_valid   = (state_q == StIssue);
  assign act_cmd     = cmd_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = err_q;
  assign led         = led_q;

endmodule

// File: tb/tb_assist_actuator_arbiter.sv
// Scoreboard bench: stimulus queues expected accepted transfers and timeout cycles,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_assist_actuator_arbiter;

  localparam int unsigned TO = 64;
  localparam int unsigned CL = 4;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] cmd;
  } txn_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] cmd_flat;
  logic        act_ready;
  logic        act_done;
  logic [3:0]  grant;
  logic        act_valid;
  logic [3:0]  act_cmd;
  logic        busy;
  logic        timeout_err;
  logic [3:0]  led;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  txn_t exp_q[$];
  int   to_q[$];

  assist_actuator_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .COOL_CYCLES    (CL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .cmd_flat    (cmd_flat),
    .act_ready   (act_ready),
    .act_done    (act_done),
    .grant       (grant),
    .act_valid   (act_valid),
    .act_cmd     (act_cmd),
    .busy        (busy),
    .timeout_err (timeout_err),
    .led         (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int c);
    for (int i = 0; i < 40 && !act_valid; i++) tick();
    if (!act_valid) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_valid: act_valid 0 after 40 cycles, required 1");
    end
    c = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    check("wait_idle_busy", busy, 0);
  endtask

  // Monitor: accepted transfers, led one cycle after acceptance, timeout pulses.
  initial begin
    logic       led_pend;
    logic [3:0] led_exp;
    txn_t       e;
    int         t;
    led_pend = 1'b0;
    led_exp  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (led_pend) begin
          check("led_after_accept", led, led_exp);
          check("valid_after_accept", act_valid, 0);
          led_pend = 1'b0;
        end
        if (act_valid && act_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_accept: grant %b cmd %h, required no transfer", grant,
                     act_cmd);
          end else begin
            e = exp_q.pop_front();
            check("accept_grant", grant, e.grant);
            check("accept_cmd", act_cmd, e.cmd);
            led_exp  = e.grant;
            led_pend = 1'b1;
          end
        end
        if (timeout_err) begin
          if (to_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_timeout: pulse at cycle %0d, required none", cyc);
          end else begin
            t = to_q.pop_front();
            check("timeout_cycle", cyc, t);
          end
        end
      end
    end
  end

  initial begin
    int vc, prev, a, t;
    reset     = 1'b1;
    req       = '0;
    cmd_flat  = '0;
    act_ready = 1'b0;
    act_done  = 1'b0;
    prev      = 0;

    // Reset state and idle hold
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_valid", act_valid, 0);
    check("rst_cmd", act_cmd, 0);
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);
    check("rst_led", led, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy", busy, 0);
      check("idle_grant", grant, 0);
    end

    // Round-robin over requesters 0..2, minimum service period 7 cycles
    cmd_flat  = 16'hF963;
    act_ready = 1'b1;
    exp_q.push_back('{grant: 4'b0001, cmd: 4'h3});
    exp_q.push_back('{grant: 4'b0010, cmd: 4'h6});
    exp_q.push_back('{grant: 4'b0100, cmd: 4'h9});
    exp_q.push_back('{grant: 4'b0001, cmd: 4'h3});
    req = 4'b0111;
    for (int s = 0; s < 4; s++) begin
      wait_valid(vc);
      if (s > 0) check("service_gap", vc - prev, 7);
      prev = vc;
      if (s == 3) req = '0;
      tick();
      act_done = 1'b1;
      tick();
      act_done = 1'b0;
    end
    wait_idle();

    // Emergency preempts an unaccepted issue
    cmd_flat  = 16'hF005;
    act_ready = 1'b0;
    req       = 4'b0001;
    wait_valid(vc);
    check("pre_grant", grant, 4'b0001);
    check("pre_cmd", act_cmd, 4'h5);
    tick();
    tick();
    req = 4'b1001;
    tick();
    check("preempt_valid", act_valid, 0);
    check("preempt_grant", grant, 0);
    tick();
    check("emerg_grant", grant, 4'b1000);
    check("emerg_cmd", act_cmd, 4'hF);
    check("emerg_valid", act_valid, 1);
    exp_q.push_back('{grant: 4'b1000, cmd: 4'hF});
    act_ready = 1'b1;
    req       = '0;
    tick();
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    wait_idle();

    // Ready wins over a coincident emergency
    act_ready = 1'b0;
    req       = 4'b0001;
    wait_valid(vc);
    tick();
    tick();
    exp_q.push_back('{grant: 4'b0001, cmd: 4'h5});
    req       = 4'b1001;
    act_ready = 1'b1;
    tick();
    a = cyc;
    check("coinc_busy", busy, 1);
    check("coinc_valid", act_valid, 0);
    check("coinc_grant", grant, 4'b0001);
    exp_q.push_back('{grant: 4'b1000, cmd: 4'hF});
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    check("coinc_cool_grant", grant, 0);
    wait_valid(vc);
    check("emerg_after_cool", vc - a, 6);
    check("emerg_late_grant", grant, 4'b1000);
    req = '0;
    tick();
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    wait_idle();

    // Timeout: no act_done after acceptance
    cmd_flat  = 16'hF0A5;
    act_ready = 1'b1;
    req       = 4'b0010;
    exp_q.push_back('{grant: 4'b0010, cmd: 4'hA});
    wait_valid(vc);
    t = vc + 1;
    to_q.push_back(t + TO);
    req = '0;
    for (int i = 0; i < 80 && cyc < t + TO - 1; i++) tick();
    check("to_pre_err", timeout_err, 0);
    check("to_pre_grant", grant, 4'b0010);
    tick();
    check("to_err", timeout_err, 1);
    check("to_grant", grant, 0);
    check("to_busy", busy, 1);
    req = 4'b0001;
    exp_q.push_back('{grant: 4'b0001, cmd: 4'h5});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("to_cool_grant", grant, 0);
      check("to_cool_err", timeout_err, 0);
      check("to_cool_busy", busy, 1);
    end
    tick();
    check("to_idle_busy", busy, 0);
    check("to_idle_grant", grant, 0);
    tick();
    check("to_rearb_grant", grant, 4'b0001);
    check("to_rearb_valid", act_valid, 1);
    req = '0;
    tick();
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    wait_idle();

    // Reset mid-WAIT_DONE with timer at 30, then pointer back at requester 0
    req = 4'b0001;
    exp_q.push_back('{grant: 4'b0001, cmd: 4'h5});
    wait_valid(vc);
    tick();
    req = '0;
    for (int i = 0; i < 30; i++) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_valid", act_valid, 0);
    check("mid_rst_cmd", act_cmd, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", timeout_err, 0);
    check("mid_rst_led", led, 0);
    tick();
    tick();
    reset    = 1'b0;
    cmd_flat = 16'hF963;
    req      = 4'b0111;
    exp_q.push_back('{grant: 4'b0001, cmd: 4'h3});
    wait_valid(vc);
    check("post_rst_grant", grant, 4'b0001);
    req = '0;
    tick();
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    wait_idle();

    check("exp_queue_empty", exp_q.size(), 0);
    check("timeout_queue_empty", to_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
